// File: rtl/be_clock_sequencer.sv
// Front-panel clock sequencer: conditions five raw pushbuttons and drives the
// clock generator mode (continuous/step), step pulses, rate select and the
// system clear, with a small five-state FSM. All outputs are registered.
module be_clock_sequencer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CLR_CYCLES      = 16,
  parameter int STEP_WIDTH      = 4
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       BTN_STEP,
  input  logic       BTN_RUN,
  input  logic       BTN_RESET,
  input  logic       BTN_FASTER,
  input  logic       BTN_SLOWER,
  input  logic       HLT_IN,
  output logic       CLK_SELECT,
  output logic       CLK_STEP,
  output logic [2:0] DIV_CLK,
  output logic       CLR,
  output logic       HALTED,
  output logic [2:0] o_dbg_state
);

  localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int MAXC = (CLR_CYCLES > STEP_WIDTH) ? CLR_CYCLES : STEP_WIDTH;
  localparam int SW   = $clog2(MAXC + 1);

  // Button bit order: 0 step, 1 run, 2 reset, 3 faster, 4 slower.
  typedef enum logic [2:0] {
    S_RESET = 3'd0,
    S_STOP  = 3'd1,
    S_STEP  = 3'd2,
    S_RUN   = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  logic [4:0]         w_btn_raw;
  logic [4:0]         r_sync1;
  logic [4:0]         r_sync2;
  logic [4:0]         r_db;
  logic [4:0]         r_db_q;
  logic [4:0][DW-1:0] r_dcnt;
  logic [4:0]         w_evt;

  state_t             r_state;
  state_t             w_next;
  logic [SW-1:0]      r_cnt;
  logic [SW-1:0]      w_cnt_next;

  assign w_btn_raw = {BTN_SLOWER, BTN_FASTER, BTN_RESET, BTN_RUN, BTN_STEP};

  // Two-flop synchronizer for the asynchronous button inputs.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Per-button debouncer: accept the new level only after it has differed
  // from the accepted one for DEBOUNCE_CYCLES consecutive cycles.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_db   <= '0;
      r_dcnt <= '0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (r_sync2[i] != r_db[i]) begin
          if (r_dcnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
            r_db[i]   <= r_sync2[i];
            r_dcnt[i] <= '0;
          end else begin
            r_dcnt[i] <= r_dcnt[i] + DW'(1);
          end
        end else begin
          r_dcnt[i] <= '0;
        end
      end
    end
  end

  // Previous debounced level, used to form one-cycle press events.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) r_db_q <= '0;
    else         r_db_q <= r_db;
  end

  assign w_evt = r_db & ~r_db_q;

  // FSM state and shared cycle counter (CLR hold length / step width).
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state <= S_RESET;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next-state logic; priority is reset > HLT_IN > run > step.
  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    if (w_evt[2]) begin
      w_next     = S_RESET;
      w_cnt_next = '0;
    end else begin
      case (r_state)
        S_RESET: begin
          if (r_cnt == SW'(CLR_CYCLES - 1)) begin
            w_next     = S_STOP;
            w_cnt_next = '0;
          end else begin
            w_cnt_next = r_cnt + SW'(1);
          end
        end
        S_STOP: begin
          if (w_evt[1]) begin
            w_next = S_RUN;
          end else if (w_evt[0]) begin
            w_next     = S_STEP;
            w_cnt_next = '0;
          end
        end
        S_STEP: begin
          // Run/step events are dropped while a step pulse is in flight.
          if (r_cnt == SW'(STEP_WIDTH - 1)) begin
            w_next     = HLT_IN ? S_HALT : S_STOP;
            w_cnt_next = '0;
          end else begin
            w_cnt_next = r_cnt + SW'(1);
          end
        end
        S_RUN: begin
          if (HLT_IN)        w_next = S_HALT;
          else if (w_evt[1]) w_next = S_STOP;
        end
        S_HALT: begin
          w_next = S_HALT;
        end
        default: begin
          w_next     = S_RESET;
          w_cnt_next = '0;
        end
      endcase
    end
  end

  // Outputs registered from the next state so they change with the state.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      CLR        <= 1'b1;
      CLK_SELECT <= 1'b1;
      CLK_STEP   <= 1'b0;
      HALTED     <= 1'b0;
    end else begin
      CLR        <= (w_next == S_RESET);
      CLK_SELECT <= (w_next != S_RUN);
      CLK_STEP   <= (w_next == S_STEP);
      HALTED     <= (w_next == S_HALT);
    end
  end

  // Rate select: saturating up/down; simultaneous events cancel.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      DIV_CLK <= 3'd0;
    end else if (w_evt[3] && !w_evt[4] && DIV_CLK != 3'd7) begin
      DIV_CLK <= DIV_CLK + 3'd1;
    end else if (w_evt[4] && !w_evt[3] && DIV_CLK != 3'd0) begin
      DIV_CLK <= DIV_CLK - 3'd1;
    end
  end

  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_be_clock_sequencer.sv
// Directed bench for be_clock_sequencer with short debounce/clear/step lengths.
module tb_be_clock_sequencer;

  logic       iCLK = 1'b0;
  logic       iRST_N;
  logic       BTN_STEP, BTN_RUN, BTN_RESET, BTN_FASTER, BTN_SLOWER, HLT_IN;
  logic       CLK_SELECT, CLK_STEP, CLR, HALTED;
  logic [2:0] DIV_CLK;
  logic [2:0] dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int n_step_pulses = 0;
  int n_step_hi     = 0;
  int base_p, base_h;

  be_clock_sequencer #(
    .DEBOUNCE_CYCLES(4),
    .CLR_CYCLES     (3),
    .STEP_WIDTH     (2)
  ) dut (
    .iCLK       (iCLK),
    .iRST_N     (iRST_N),
    .BTN_STEP   (BTN_STEP),
    .BTN_RUN    (BTN_RUN),
    .BTN_RESET  (BTN_RESET),
    .BTN_FASTER (BTN_FASTER),
    .BTN_SLOWER (BTN_SLOWER),
    .HLT_IN     (HLT_IN),
    .CLK_SELECT (CLK_SELECT),
    .CLK_STEP   (CLK_STEP),
    .DIV_CLK    (DIV_CLK),
    .CLR        (CLR),
    .HALTED     (HALTED),
    .o_dbg_state(dbg_state)
  );

  // Clock
  always #5 iCLK = ~iCLK;

  // Step pulse count and total high cycles.
  always @(posedge CLK_STEP) n_step_pulses++;
  always @(negedge iCLK) if (CLK_STEP === 1'b1) n_step_hi++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic set_btn(input int idx, input logic v);
    case (idx)
      0: BTN_STEP   = v;
      1: BTN_RUN    = v;
      2: BTN_RESET  = v;
      3: BTN_FASTER = v;
      default: BTN_SLOWER = v;
    endcase
  endtask

  // Clean press: held long enough to debounce, then released and settled.
  task automatic press_release(input int idx);
    set_btn(idx, 1'b1);
    repeat (8) tick();
    set_btn(idx, 1'b0);
    repeat (8) tick();
  endtask

  initial begin
    iRST_N = 1'b0;
    BTN_STEP = 0; BTN_RUN = 0; BTN_RESET = 0; BTN_FASTER = 0; BTN_SLOWER = 0;
    HLT_IN = 0;
    repeat (3) tick();
    check("rst_clr", CLR, 1);
    check("rst_sel", CLK_SELECT, 1);
    check("rst_step", CLK_STEP, 0);
    check("rst_div", DIV_CLK, 0);
    check("rst_halted", HALTED, 0);

    // Power-on clear sequence: CLR held three cycles after release.
    iRST_N = 1'b1;
    tick(); check("por_clr1", CLR, 1);
    tick(); check("por_clr2", CLR, 1);
    tick(); check("por_clr_done", CLR, 0);
    check("por_sel", CLK_SELECT, 1);
    check("por_div", DIV_CLK, 0);

    // Glitches must not produce a step, then a held press gives one pulse.
    base_p = n_step_pulses;
    base_h = n_step_hi;
    repeat (3) begin
      BTN_STEP = 1; tick();
      BTN_STEP = 0; tick(); tick();
    end
    repeat (4) tick();
    check("glitch_no_step", n_step_pulses - base_p, 0);
    BTN_STEP = 1;
    repeat (6) tick();
    check("step_before", CLK_STEP, 0);
    tick(); check("step_on1", CLK_STEP, 1);
    tick(); check("step_on2", CLK_STEP, 1);
    tick(); check("step_off", CLK_STEP, 0);
    check("step_sel", CLK_SELECT, 1);
    tick();
    BTN_STEP = 0;
    repeat (10) tick();
    check("step_pulses", n_step_pulses - base_p, 1);
    check("step_width", n_step_hi - base_h, 2);
    check("step_back_stop_sel", CLK_SELECT, 1);
    check("step_back_stop_clr", CLR, 0);

    // Rate select up to saturation.
    press_release(3);
    check("div_first", DIV_CLK, 1);
    repeat (8) press_release(3);
    check("div_max", DIV_CLK, 7);

    // Reset event leaves the rate alone.
    press_release(2);
    check("div_after_reset", DIV_CLK, 7);
    check("reset_done_clr", CLR, 0);

    // Simultaneous faster + slower cancels.
    BTN_FASTER = 1; BTN_SLOWER = 1;
    repeat (8) tick();
    BTN_FASTER = 0; BTN_SLOWER = 0;
    repeat (8) tick();
    check("div_both", DIV_CLK, 7);
    press_release(4);
    check("div_dec1", DIV_CLK, 6);
    repeat (7) press_release(4);
    check("div_min", DIV_CLK, 0);
    press_release(4);
    check("div_min_sat", DIV_CLK, 0);

    // Run, then halt; run/step are ignored while halted.
    BTN_RUN = 1;
    repeat (6) tick();
    check("run_before", CLK_SELECT, 1);
    tick(); check("run_sel", CLK_SELECT, 0);
    BTN_RUN = 0;
    repeat (10) tick();
    check("run_release_sel", CLK_SELECT, 0);
    check("run_not_halted", HALTED, 0);
    HLT_IN = 1;
    tick();
    check("halt_halted", HALTED, 1);
    check("halt_sel", CLK_SELECT, 1);
    HLT_IN = 0;
    base_p = n_step_pulses;
    press_release(1);
    check("halt_run_ignored", HALTED, 1);
    press_release(0);
    check("halt_step_ignored", HALTED, 1);
    check("halt_no_pulse", n_step_pulses - base_p, 0);

    // Reset event exits HALT through the clear sequence.
    BTN_RESET = 1;
    repeat (6) tick();
    check("hrst_before_clr", CLR, 0);
    check("hrst_before_halted", HALTED, 1);
    tick(); check("hrst_clr1", CLR, 1); check("hrst_halted", HALTED, 0);
    tick(); check("hrst_clr2", CLR, 1);
    tick(); check("hrst_clr3", CLR, 1);
    tick(); check("hrst_clr_done", CLR, 0);
    check("hrst_sel", CLK_SELECT, 1);
    BTN_RESET = 0;
    repeat (8) tick();

    // Reset event on the first STEP cycle cuts the pulse short.
    base_p = n_step_pulses;
    BTN_STEP = 1;
    tick();
    BTN_RESET = 1;
    repeat (5) tick();
    check("srst_before", CLK_STEP, 0);
    tick(); check("srst_step_on", CLK_STEP, 1); check("srst_clr_low", CLR, 0);
    tick(); check("srst_step_cut", CLK_STEP, 0); check("srst_clr1", CLR, 1);
    tick(); check("srst_clr2", CLR, 1);
    tick(); check("srst_clr3", CLR, 1);
    tick(); check("srst_clr_done", CLR, 0);
    check("srst_sel", CLK_SELECT, 1);
    BTN_STEP = 0; BTN_RESET = 0;
    repeat (10) tick();
    check("srst_pulses", n_step_pulses - base_p, 1);
    check("srst_idle_step", CLK_STEP, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
